// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC predictor: MIPS control-flow opcodes,
// fetch FSM states, 2-bit counter encodings and the fetch-stage predecoder.
package npc_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    localparam logic [4:0] REG_RA     = 5'd31;

    localparam logic [1:0] CTR_SNT    = 2'b00;
    localparam logic [1:0] CTR_WNT    = 2'b01;
    localparam logic [1:0] CTR_WT     = 2'b10;
    localparam logic [1:0] CTR_ST     = 2'b11;

    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_SLOT = 1'b1
    } npc_state_e;

    typedef struct packed {
        logic cond;   // conditional branch, BHT-predicted
        logic jabs;   // J/JAL, always taken to an absolute target
        logic ret;    // JR $31
        logic call;   // JAL/JALR, pushes a return address
    } predec_t;

    function automatic predec_t predecode(input logic [31:0] instr);
        predec_t pd;
        pd.cond = 1'b0;
        pd.jabs = 1'b0;
        pd.ret  = 1'b0;
        pd.call = 1'b0;
        case (instr[31:26])
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: pd.cond = 1'b1;
            OP_REGIMM: pd.cond = (instr[20:16] == RT_BLTZ) ||
                                 (instr[20:16] == RT_BGEZ) ||
                                 (instr[20:16] == RT_BGEZAL);
            OP_J:   pd.jabs = 1'b1;
            OP_JAL: begin
                pd.jabs = 1'b1;
                pd.call = 1'b1;
            end
            OP_SPECIAL: begin
                if ((instr[5:0] == FN_JR) && (instr[25:21] == REG_RA)) begin
                    pd.ret = 1'b1;
                end else if (instr[5:0] == FN_JALR) begin
                    pd.call = 1'b1;
                end else begin
                    pd.ret = 1'b0;
                end
            end
            default: pd.cond = 1'b0;
        endcase
        return pd;
    endfunction

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module npc_ras
    import npc_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [31:0]   mem_r [RAS_DEPTH];
    logic [PW-1:0] ptr_r;
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] top_idx_s;

    // The count tracks outstanding calls beyond the depth, so returns from
    // over-deep nesting still get a (wrapped, possibly stale) guess.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= {PW{1'b0}};
            cnt_r <= {CW{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (push) begin
            mem_r[ptr_r] <= push_addr;
            ptr_r        <= ptr_r + 1'b1;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 1'b1;
            end
        end else if (pop && (cnt_r != {CW{1'b0}})) begin
            ptr_r <= ptr_r - 1'b1;
            cnt_r <= cnt_r - 1'b1;
        end
    end

    assign top_idx_s = ptr_r - 1'b1;
    assign top       = mem_r[top_idx_s];
    assign empty     = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/npc_predict.sv
// Fetch next-PC predictor for a delay-slot MIPS pipeline: 2-bit BHT, RAS,
// SEQ/SLOT redirect FSM and EX-stage mispredict recovery.
module npc_predict
    import npc_pkg::*;
#(
    parameter int          BHT_DEPTH = 64,
    parameter int          RAS_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [31:0] instr_if,
    output logic [31:0] pc,
    output logic        pred_taken_if,
    output logic [31:0] pred_target_if,
    input  logic        ex_valid,
    input  logic        ex_is_cond,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        flush
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [31:0]    pc_r;
    logic [31:0]    tgt_r;
    npc_state_e     state_r;
    logic [1:0]     bht_r [BHT_DEPTH];

    predec_t        pd_s;
    logic [IDX-1:0] if_idx_s;
    logic [IDX-1:0] ex_idx_s;
    logic [1:0]     if_ctr_s;
    logic [1:0]     ex_ctr_s;
    logic [31:0]    pc4_s;
    logic [31:0]    pc8_s;
    logic [31:0]    br_tgt_s;
    logic [31:0]    jabs_tgt_s;
    logic [31:0]    ras_top_s;
    logic           ras_empty_s;
    logic           push_s;
    logic           pop_s;
    logic           pred_taken_s;
    logic [31:0]    pred_target_s;
    logic           mispredict_s;
    logic [31:0]    redirect_s;

    assign pd_s       = predecode(instr_if);
    assign if_idx_s   = pc_r[IDX+1:2];
    assign ex_idx_s   = ex_pc[IDX+1:2];
    assign if_ctr_s   = bht_r[if_idx_s];
    assign ex_ctr_s   = bht_r[ex_idx_s];
    assign pc4_s      = pc_r + 32'd4;
    assign pc8_s      = pc_r + 32'd8;
    assign br_tgt_s   = pc4_s + {{14{instr_if[15]}}, instr_if[15:0], 2'b00};
    assign jabs_tgt_s = {pc4_s[31:28], instr_if[25:0], 2'b00};
    assign push_s     = !stall && pd_s.call;
    assign pop_s      = !stall && pd_s.ret;

    npc_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_addr (pc8_s),
        .top       (ras_top_s),
        .empty     (ras_empty_s)
    );

    // Direction/target prediction for the instruction currently at pc.
    always_comb begin
        pred_taken_s  = 1'b0;
        pred_target_s = pc8_s;
        if (pd_s.cond) begin
            pred_taken_s  = if_ctr_s[1];
            pred_target_s = br_tgt_s;
        end else if (pd_s.jabs) begin
            pred_taken_s  = 1'b1;
            pred_target_s = jabs_tgt_s;
        end else if (pd_s.ret) begin
            pred_taken_s  = !ras_empty_s;
            pred_target_s = ras_empty_s ? pc8_s : ras_top_s;
        end else begin
            pred_taken_s  = 1'b0;
            pred_target_s = pc8_s;
        end
    end

    assign mispredict_s   = ex_valid && ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_s     = ex_taken ? ex_target : (ex_pc + 32'd8);
    assign flush          = mispredict_s;
    assign pc             = pc_r;
    assign pred_taken_if  = pred_taken_s;
    assign pred_target_if = pred_target_s;

    // Fetch FSM: a taken prediction first fetches the delay slot, then the target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_r    <= RESET_PC;
            state_r <= ST_SEQ;
            tgt_r   <= 32'h0000_0000;
        end else if (mispredict_s) begin
            pc_r    <= redirect_s;
            state_r <= ST_SEQ;
        end else if (!stall) begin
            case (state_r)
                ST_SEQ: begin
                    pc_r <= pc4_s;
                    if (pred_taken_s) begin
                        tgt_r   <= pred_target_s;
                        state_r <= ST_SLOT;
                    end
                end
                ST_SLOT: begin
                    pc_r    <= tgt_r;
                    state_r <= ST_SEQ;
                end
                default: begin
                    pc_r    <= pc4_s;
                    state_r <= ST_SEQ;
                end
            endcase
        end
    end

    // BHT training from EX; the IF read above sees the pre-update value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_r[i] <= CTR_WNT;
            end
        end else if (ex_valid && ex_is_cond) begin
            if (ex_taken && (ex_ctr_s != CTR_ST)) begin
                bht_r[ex_idx_s] <= ex_ctr_s + 2'b01;
            end else if (!ex_taken && (ex_ctr_s != CTR_SNT)) begin
                bht_r[ex_idx_s] <= ex_ctr_s - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_npc_predict.sv
// Self-checking bench for npc_predict: directed cycle tables, hand sequences
// for RAS/stall/counter corners, and random stimulus against a reference model.
module tb_npc_predict;

    localparam int D = 4;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] BEQ4  = 32'h1000_0004;
    localparam logic [31:0] JR31  = 32'h03E0_0008;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr_if = 32'h0;
    logic [31:0] pc;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        ex_valid = 1'b0;
    logic        ex_is_cond = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'h0;
    logic        flush;

    int errors = 0;
    int checks = 0;

    npc_predict #(.BHT_DEPTH(64), .RAS_DEPTH(D), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .instr_if(instr_if),
        .pc(pc), .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] ins;
        logic        ev, ec;
        logic [31:0] ep;
        logic        et;
        logic [31:0] etg;
        logic        ept;
        logic [31:0] eptg;
        logic [31:0] x_pc;
        logic        x_pt;
        logic        ct;
        logic [31:0] x_tgt;
        logic        x_fl;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [31:0] ins, input logic [31:0] xpc,
                                input logic xpt, input logic ct, input logic [31:0] xtgt,
                                input logic xfl);
        vec_t r;
        r.st = st; r.ins = ins; r.ev = 1'b0; r.ec = 1'b0; r.ep = 32'h0; r.et = 1'b0;
        r.etg = 32'h0; r.ept = 1'b0; r.eptg = 32'h0; r.x_pc = xpc; r.x_pt = xpt;
        r.ct = ct; r.x_tgt = xtgt; r.x_fl = xfl;
        return r;
    endfunction

    function automatic vec_t add_ex(input vec_t b, input logic ec, input logic [31:0] ep,
                                    input logic et, input logic [31:0] etg,
                                    input logic ept, input logic [31:0] eptg);
        b.ev = 1'b1; b.ec = ec; b.ep = ep; b.et = et; b.etg = etg; b.ept = ept; b.eptg = eptg;
        return b;
    endfunction

    function automatic logic [31:0] jal_to(input logic [31:0] a);
        logic [31:0] r;
        r = {6'h03, a[27:2]};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; drives, checks, and returns at the next falling edge.
    task automatic apply(input vec_t v, input string nm);
        stall = v.st; instr_if = v.ins; ex_valid = v.ev; ex_is_cond = v.ec; ex_pc = v.ep;
        ex_taken = v.et; ex_target = v.etg; ex_pred_taken = v.ept; ex_pred_target = v.eptg;
        #1;
        chk({nm, " pc"}, pc, v.x_pc);
        chk({nm, " pred_taken"}, {31'd0, pred_taken_if}, {31'd0, v.x_pt});
        if (v.ct) chk({nm, " pred_target"}, pred_target_if, v.x_tgt);
        chk({nm, " flush"}, {31'd0, flush}, {31'd0, v.x_fl});
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset_n = 1'b0; stall = 1'b0; instr_if = NOP; ex_valid = 1'b0;
        #2;
        chk({nm, " reset pc"}, pc, 32'h0000_3000);
        chk({nm, " reset flush"}, {31'd0, flush}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    vec_t tbl [17];
    vec_t v;
    logic [31:0] rets [5];

    // reference model state
    logic [31:0] m_pc, m_tgt;
    bit          m_slot;
    int          m_bht [64];
    logic [31:0] m_ras [D];
    int          m_sp, m_cnt;

    initial begin
        // ---------------- directed table ----------------
        tbl[0]  = mk(1'b0, NOP, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[1]  = mk(1'b0, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[2]  = mk(1'b0, NOP, 32'h3008, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[3]  = add_ex(mk(1'b0, NOP, 32'h300C, 1'b0, 1'b0, 32'h0, 1'b1),
                         1'b0, 32'h2000, 1'b1, 32'h3000, 1'b0, 32'h0);
        tbl[4]  = mk(1'b0, BEQ4, 32'h3000, 1'b0, 1'b1, 32'h3014, 1'b0);
        tbl[5]  = add_ex(mk(1'b0, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b1),
                         1'b1, 32'h3000, 1'b1, 32'h3014, 1'b0, 32'h3014);
        tbl[6]  = add_ex(mk(1'b0, NOP, 32'h3014, 1'b0, 1'b0, 32'h0, 1'b1),
                         1'b0, 32'h2000, 1'b1, 32'h3000, 1'b0, 32'h0);
        tbl[7]  = mk(1'b0, BEQ4, 32'h3000, 1'b1, 1'b1, 32'h3014, 1'b0);
        tbl[8]  = mk(1'b0, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[9]  = add_ex(mk(1'b0, NOP, 32'h3014, 1'b0, 1'b0, 32'h0, 1'b1),
                         1'b0, 32'h2000, 1'b1, 32'h3000, 1'b0, 32'h0);
        tbl[10] = mk(1'b0, jal_to(32'h3100), 32'h3000, 1'b1, 1'b1, 32'h3100, 1'b0);
        tbl[11] = mk(1'b0, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[12] = mk(1'b0, JR31, 32'h3100, 1'b1, 1'b1, 32'h3008, 1'b0);
        tbl[13] = mk(1'b0, NOP, 32'h3104, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[14] = mk(1'b0, NOP, 32'h3008, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[15] = mk(1'b0, JR31, 32'h300C, 1'b0, 1'b1, 32'h3014, 1'b0);
        tbl[16] = mk(1'b0, NOP, 32'h3010, 1'b0, 1'b0, 32'h0, 1'b0);

        do_reset("init");
        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // ---------------- RAS overflow: 5 nested calls, 5 returns ----------------
        do_reset("ras");
        for (int k = 0; k < 5; k++) begin
            apply(mk(1'b0, jal_to(32'h3000 + 32'h100 * (k + 1)), 32'h3000 + 32'h100 * k,
                     1'b1, 1'b1, 32'h3000 + 32'h100 * (k + 1), 1'b0), $sformatf("call%0d", k));
            apply(mk(1'b0, NOP, 32'h3004 + 32'h100 * k, 1'b0, 1'b0, 32'h0, 1'b0),
                  $sformatf("callslot%0d", k));
        end
        rets[0] = 32'h3408; rets[1] = 32'h3308; rets[2] = 32'h3208;
        rets[3] = 32'h3108; rets[4] = 32'h3408;
        for (int r = 0; r < 5; r++) begin
            logic [31:0] rpc;
            rpc = (r == 0) ? 32'h3500 : rets[r - 1];
            apply(mk(1'b0, JR31, rpc, 1'b1, 1'b1, rets[r], 1'b0), $sformatf("ret%0d", r));
            if (r < 4) begin
                apply(mk(1'b0, NOP, rpc + 32'd4, 1'b0, 1'b0, 32'h0, 1'b0),
                      $sformatf("retslot%0d", r));
            end else begin
                apply(add_ex(mk(1'b0, NOP, rpc + 32'd4, 1'b0, 1'b0, 32'h0, 1'b1),
                             1'b0, rpc, 1'b1, 32'h3008, 1'b1, 32'h3408), "ret4 mispredict");
            end
        end
        apply(mk(1'b0, NOP, 32'h3008, 1'b0, 1'b0, 32'h0, 1'b0), "ret4 recover");

        // ---------------- stall in SLOT, mispredict under stall ----------------
        do_reset("stall");
        apply(mk(1'b0, jal_to(32'h3100), 32'h3000, 1'b1, 1'b1, 32'h3100, 1'b0), "st jal");
        for (int s = 0; s < 3; s++)
            apply(mk(1'b1, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0), $sformatf("st hold%0d", s));
        apply(mk(1'b0, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0), "st release");
        apply(mk(1'b0, jal_to(32'h3200), 32'h3100, 1'b1, 1'b1, 32'h3200, 1'b0), "st jal2");
        apply(add_ex(mk(1'b1, NOP, 32'h3104, 1'b0, 1'b0, 32'h0, 1'b1),
                     1'b0, 32'h3050, 1'b0, 32'h0, 1'b1, 32'h3200), "st mispredict");
        apply(mk(1'b1, NOP, 32'h3058, 1'b0, 1'b0, 32'h0, 1'b0), "st redirect");

        // ---------------- counter saturation at index 0 (pc held by stall) ----------------
        do_reset("ctr");
        begin
            // {update?, taken, expected prediction seen this cycle (old value)}
            logic [2:0] seq [16];
            seq[0] = 3'b110; seq[1] = 3'b111; seq[2] = 3'b111; seq[3] = 3'b111; seq[4] = 3'b111;
            seq[5] = 3'b101; seq[6] = 3'b001; seq[7] = 3'b101; seq[8] = 3'b100; seq[9] = 3'b100;
            seq[10] = 3'b100; seq[11] = 3'b100; seq[12] = 3'b110; seq[13] = 3'b000;
            seq[14] = 3'b110; seq[15] = 3'b001;
            for (int c = 0; c < 16; c++) begin
                v = mk(1'b1, BEQ4, 32'h3000, seq[c][0], 1'b1, 32'h3014, 1'b0);
                if (seq[c][2]) v = add_ex(v, 1'b1, 32'h3000, seq[c][1], 32'h3014,
                                          seq[c][1], 32'h3014);
                apply(v, $sformatf("ctr%0d", c));
            end
        end
        apply(mk(1'b0, NOP, 32'h3000, 1'b0, 1'b0, 32'h0, 1'b0), "mid run0");
        apply(mk(1'b0, NOP, 32'h3004, 1'b0, 1'b0, 32'h0, 1'b0), "mid run1");
        do_reset("pulse");
        apply(add_ex(mk(1'b1, BEQ4, 32'h3000, 1'b0, 1'b1, 32'h3014, 1'b0),
                     1'b1, 32'h3000, 1'b1, 32'h3014, 1'b1, 32'h3014), "pulse ctr01");
        apply(mk(1'b1, BEQ4, 32'h3000, 1'b1, 1'b1, 32'h3014, 1'b0), "pulse ctr10");

        // ---------------- random stimulus vs reference model ----------------
        do_reset("rand");
        m_pc = 32'h3000; m_tgt = 32'h0; m_slot = 1'b0; m_sp = 0; m_cnt = 0;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        for (int i = 0; i < D; i++) m_ras[i] = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins, e_tgt, ep, etg, eptg;
            logic [5:0]  op, fn;
            logic [4:0]  rs, rt;
            logic        cnd, jab, cal, ret, e_pt, ct, ev, ec, et, ept, st, e_mp;
            int          sel, bi, imm;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: ins = {6'h00, 20'($urandom), 6'h20};
                2: ins = {6'h04 + 6'($urandom_range(0, 3)), 10'($urandom), 16'($urandom)};
                3: begin
                    bi = $urandom_range(0, 3);
                    ins = {6'h01, 5'($urandom), (bi == 0) ? 5'h00 : (bi == 1) ? 5'h01 :
                           (bi == 2) ? 5'h11 : 5'h10, 16'($urandom)};
                end
                4: ins = {6'h02, 26'($urandom)};
                5: ins = {6'h03, 26'($urandom)};
                6, 7: ins = JR31;
                8: ins = {6'h00, 5'($urandom_range(1, 30)), 15'd0, 6'h08};
                default: ins = {6'h00, 5'($urandom), 5'd0, 5'd31, 5'd0, 6'h09};
            endcase
            op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16];
            cnd = (op >= 6'd4 && op <= 6'd7) || (op == 6'd1 && (rt == 5'd0 || rt == 5'd1 || rt == 5'd17));
            jab = (op == 6'd2) || (op == 6'd3);
            cal = (op == 6'd3) || (op == 6'd0 && fn == 6'd9);
            ret = (op == 6'd0) && (fn == 6'd8) && (rs == 5'd31);
            e_pt = 1'b0; ct = 1'b1; e_tgt = 32'h0;
            if (cnd) begin
                bi = int'((m_pc >> 2) % 64);
                imm = int'($signed(ins[15:0]));
                e_pt = (m_bht[bi] >= 2);
                e_tgt = m_pc + 32'd4 + 32'(imm * 4);
            end else if (jab) begin
                e_pt = 1'b1;
                e_tgt = ((m_pc + 32'd4) & 32'hF000_0000) + (32'(ins[25:0]) * 32'd4);
            end else if (ret) begin
                e_pt = (m_cnt > 0);
                e_tgt = (m_cnt > 0) ? m_ras[(m_sp + D - 1) % D] : m_pc + 32'd8;
            end else begin
                ct = 1'b0;
            end
            ev = ($urandom_range(0, 9) < 3); ec = 1'($urandom);
            ep = 32'h3000 | ($urandom & 32'hFC); et = 1'($urandom);
            etg = $urandom & 32'hFFFF_FFFC;
            ept = ($urandom_range(0, 9) < 7) ? et : !et;
            eptg = ($urandom_range(0, 9) < 7) ? etg : ($urandom & 32'hFFFF_FFFC);
            st = ($urandom_range(0, 3) == 0);
            e_mp = ev && ((et != ept) || (et && (etg != eptg)));
            v = mk(st, ins, m_pc, e_pt, ct, e_tgt, e_mp);
            if (ev) v = add_ex(v, ec, ep, et, etg, ept, eptg);
            apply(v, $sformatf("rand%0d", n));
            if (ev && ec) begin
                bi = int'((ep >> 2) % 64);
                if (et && m_bht[bi] < 3) m_bht[bi]++;
                else if (!et && m_bht[bi] > 0) m_bht[bi]--;
            end
            if (!st && cal) begin
                m_ras[m_sp] = m_pc + 32'd8;
                m_sp = (m_sp + 1) % D;
                if (m_cnt < 2 * D - 1) m_cnt++;
            end else if (!st && ret && m_cnt > 0) begin
                m_sp = (m_sp + D - 1) % D;
                m_cnt--;
            end
            if (e_mp) begin
                m_pc = et ? etg : ep + 32'd8;
                m_slot = 1'b0;
            end else if (!st) begin
                if (m_slot) begin
                    m_pc = m_tgt; m_slot = 1'b0;
                end else if (e_pt) begin
                    m_tgt = e_tgt; m_pc = m_pc + 32'd4; m_slot = 1'b1;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
